// File: rtl/reg_file_sb.sv
// Register file with a per-register busy scoreboard.
// Two combinational read ports, one synchronous write-back port, an allocate port that marks a
// destination busy, a flush that clears all busy bits, and a registered busy population count.
// Optional same-cycle write-to-read bypass is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] raddr1_i,
  input  logic [ADDR_WIDTH-1:0] raddr2_i,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic [DATA_WIDTH-1:0] rdata2_o,
  output logic                  rbusy1_o,
  output logic                  rbusy2_o,
  input  logic                  wen_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  alloc_en_i,
  input  logic [ADDR_WIDTH-1:0] alloc_addr_i,
  input  logic                  flush_i,
  output logic [ADDR_WIDTH:0]   busy_cnt_o
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [Depth];
  logic [Depth-1:0]      busy_q, busy_d;
  logic [ADDR_WIDTH:0]   busy_cnt_q, busy_cnt_d;

  logic                  write_ok;
  logic                  alloc_ok;
  logic [ADDR_WIDTH-1:0] raddr [2];
  logic [DATA_WIDTH-1:0] rdata [2];
  logic                  rbusy [2];

  // Register 0 is hardwired when ZERO_REG is set: no writes, no allocation.
  assign write_ok = wen_i && !(ZERO_REG && (waddr_i == '0));
  assign alloc_ok = alloc_en_i && !(ZERO_REG && (alloc_addr_i == '0));

  assign raddr[0] = raddr1_i;
  assign raddr[1] = raddr2_i;

  // Next busy vector: write-back clears, allocate (newer producer) sets, flush clears all.
  always_comb begin
    busy_d = busy_q;
    if (write_ok) busy_d[waddr_i] = 1'b0;
    if (alloc_ok) busy_d[alloc_addr_i] = 1'b1;
    if (flush_i) busy_d = '0;
  end

  // Population count of the next busy vector so the count tracks the bits on the same edge.
  always_comb begin
    busy_cnt_d = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      busy_cnt_d = busy_cnt_d + {{ADDR_WIDTH{1'b0}}, busy_d[i]};
    end
  end

  // Data storage; a write in a flush cycle still lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < Depth; i++) regs_q[i] <= '0;
    end else if (write_ok) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Busy bits and their count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Combinational read ports, optionally forwarding the in-flight write-back.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = regs_q[raddr[p]];
      rbusy[p] = busy_q[raddr[p]];
`ifdef REG_FILE_BYPASS_EN
      if (write_ok && (waddr_i == raddr[p])) begin
        rdata[p] = wdata_i;
        rbusy[p] = alloc_en_i && (alloc_addr_i == raddr[p]);
      end
`endif
      if (ZERO_REG && (raddr[p] == '0)) begin
        rdata[p] = '0;
        rbusy[p] = 1'b0;
      end
    end
  end

  assign rdata1_o   = rdata[0];
  assign rdata2_o   = rdata[1];
  assign rbusy1_o   = rbusy[0];
  assign rbusy2_o   = rbusy[1];
  assign busy_cnt_o = busy_cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb (default parameters) with a behavioural scoreboard model.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  raddr1 = '0, raddr2 = '0, waddr = '0, alloc_addr = '0;
  logic [31:0] rdata1, rdata2, wdata = '0;
  logic        rbusy1, rbusy2;
  logic        wen = 1'b0, alloc_en = 1'b0, flush = 1'b0;
  logic [5:0]  busy_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: plain arrays of register values and busy flags.
  logic [31:0] mdl_data [32];
  logic [31:0] mdl_busy;

  reg_file_sb dut (
    .clk          (clk),
    .rst          (rst),
    .raddr1_i     (raddr1),
    .raddr2_i     (raddr2),
    .rdata1_o     (rdata1),
    .rdata2_o     (rdata2),
    .rbusy1_o     (rbusy1),
    .rbusy2_o     (rbusy2),
    .wen_i        (wen),
    .waddr_i      (waddr),
    .wdata_i      (wdata),
    .alloc_en_i   (alloc_en),
    .alloc_addr_i (alloc_addr),
    .flush_i      (flush),
    .busy_cnt_o   (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic mdl_reset();
    for (int i = 0; i < 32; i++) mdl_data[i] = '0;
    mdl_busy = '0;
  endtask

  // Expected read value given model state and the inputs currently applied.
  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
    if (wen && waddr == a) return wdata;
`endif
    return mdl_data[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
`ifdef REG_FILE_BYPASS_EN
    if (wen && waddr == a) return alloc_en && (alloc_addr == a);
`endif
    return mdl_busy[a];
  endfunction

  // Advance one edge: update the model from the applied inputs, then return inputs to idle.
  task automatic tick();
    if (wen && waddr != 0) begin
      mdl_data[waddr] = wdata;
      mdl_busy[waddr] = 1'b0;
    end
    if (alloc_en && alloc_addr != 0) mdl_busy[alloc_addr] = 1'b1;
    if (flush) mdl_busy = '0;
    @(posedge clk);
    #1;
    wen = 1'b0; alloc_en = 1'b0; flush = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    mdl_reset();
    raddr1 = 5'd5;
    #1;
    n_cmp++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL reset_init_cnt got %0d want 0", busy_cnt); end
    rst = 1'b1;
    tick();
    wen = 1'b1; waddr = 5'd5; wdata = 32'h1234; alloc_en = 1'b1; alloc_addr = 5'd5;
    tick();
    n_cmp++; if (rdata1 !== 32'h1234) begin n_err++; $display("FAIL preload_data got %h want 00001234", rdata1); end
    n_cmp++; if (rbusy1 !== 1'b1) begin n_err++; $display("FAIL preload_busy got %b want 1", rbusy1); end
    rst = 1'b0;
    #1;
    mdl_reset();
    n_cmp++; if (rdata1 !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", rdata1); end
    n_cmp++; if (rbusy1 !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", rbusy1); end
    n_cmp++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", busy_cnt); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_zero_reg();
    wen = 1'b1; waddr = 5'd0; wdata = 32'hDEADBEEF; alloc_en = 1'b1; alloc_addr = 5'd0;
    tick();
    raddr1 = 5'd0;
    #1;
    n_cmp++; if (rdata1 !== 32'h0) begin n_err++; $display("FAIL zero_data got %h want 0", rdata1); end
    n_cmp++; if (rbusy1 !== 1'b0) begin n_err++; $display("FAIL zero_busy got %b want 0", rbusy1); end
    n_cmp++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL zero_cnt got %0d want 0", busy_cnt); end
  endtask

  task automatic test_alloc_writeback();
    alloc_en = 1'b1; alloc_addr = 5'd3;
    tick();
    raddr2 = 5'd3;
    #1;
    n_cmp++; if (rbusy2 !== 1'b1) begin n_err++; $display("FAIL alloc_busy got %b want 1", rbusy2); end
    n_cmp++; if (busy_cnt !== 6'd1) begin n_err++; $display("FAIL alloc_cnt got %0d want 1", busy_cnt); end
    wen = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5;
    tick();
    n_cmp++; if (rdata2 !== 32'hA5A5A5A5) begin n_err++; $display("FAIL wb_data got %h want a5a5a5a5", rdata2); end
    n_cmp++; if (rbusy2 !== 1'b0) begin n_err++; $display("FAIL wb_busy got %b want 0", rbusy2); end
    n_cmp++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL wb_cnt got %0d want 0", busy_cnt); end
  endtask

  task automatic test_same_cycle();
    raddr1 = 5'd7;
    wen = 1'b1; waddr = 5'd7; wdata = 32'h11; alloc_en = 1'b1; alloc_addr = 5'd7;
    tick();
    n_cmp++; if (rdata1 !== 32'h11) begin n_err++; $display("FAIL same_data got %h want 11", rdata1); end
    n_cmp++; if (rbusy1 !== 1'b1) begin n_err++; $display("FAIL same_busy got %b want 1", rbusy1); end
    n_cmp++; if (busy_cnt !== 6'd1) begin n_err++; $display("FAIL same_cnt got %0d want 1", busy_cnt); end
    wen = 1'b1; waddr = 5'd7; wdata = 32'h11;
    tick();
  endtask

  task automatic test_flush();
    logic [4:0] list [3];
    list[0] = 5'd1; list[1] = 5'd2; list[2] = 5'd4;
    for (int i = 0; i < 3; i++) begin
      alloc_en = 1'b1; alloc_addr = list[i];
      tick();
    end
    n_cmp++; if (busy_cnt !== 6'd3) begin n_err++; $display("FAIL flush_pre_cnt got %0d want 3", busy_cnt); end
    flush = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd9;
    tick();
    n_cmp++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL flush_cnt got %0d want 0", busy_cnt); end
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a);
      #1;
      n_cmp++;
      if (rbusy1 !== 1'b0) begin n_err++; $display("FAIL flush_busy r%0d got %b want 0", a, rbusy1); end
    end
  endtask

  task automatic test_fill();
    for (int a = 0; a < 32; a++) begin
      alloc_en = 1'b1; alloc_addr = 5'(a);
      tick();
    end
    n_cmp++; if (busy_cnt !== 6'd31) begin n_err++; $display("FAIL fill_cnt got %0d want 31", busy_cnt); end
    alloc_en = 1'b1; alloc_addr = 5'd5;
    tick();
    n_cmp++; if (busy_cnt !== 6'd31) begin n_err++; $display("FAIL realloc_cnt got %0d want 31", busy_cnt); end
    flush = 1'b1;
    tick();
    n_cmp++; if (busy_cnt !== 6'd0) begin n_err++; $display("FAIL fill_flush_cnt got %0d want 0", busy_cnt); end
  endtask

  task automatic test_bypass();
    logic [31:0] old;
    alloc_en = 1'b1; alloc_addr = 5'd6;
    tick();
    old = mdl_data[6];
    raddr1 = 5'd6;
    wen = 1'b1; waddr = 5'd6; wdata = 32'h77;
    #1;
`ifdef REG_FILE_BYPASS_EN
    n_cmp++; if (rdata1 !== 32'h77) begin n_err++; $display("FAIL bypass_data got %h want 77", rdata1); end
    n_cmp++; if (rbusy1 !== 1'b0) begin n_err++; $display("FAIL bypass_busy got %b want 0", rbusy1); end
`else
    n_cmp++; if (rdata1 !== old) begin n_err++; $display("FAIL nobypass_data got %h want %h", rdata1, old); end
    n_cmp++; if (rbusy1 !== 1'b1) begin n_err++; $display("FAIL nobypass_busy got %b want 1", rbusy1); end
`endif
    tick();
    n_cmp++; if (rdata1 !== 32'h77) begin n_err++; $display("FAIL bypass_after_data got %h want 77", rdata1); end
    n_cmp++; if (rbusy1 !== 1'b0) begin n_err++; $display("FAIL bypass_after_busy got %b want 0", rbusy1); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      raddr1     = 5'($urandom_range(0, 31));
      raddr2     = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      wen        = 1'($urandom_range(0, 1));
      waddr      = 5'($urandom_range(0, 31));
      wdata      = $urandom;
      alloc_en   = ($urandom_range(0, 2) != 0);
      alloc_addr = ($urandom_range(0, 4) == 0) ? waddr : 5'($urandom_range(0, 31));
      flush      = ($urandom_range(0, 15) == 0);
      #1;
      n_cmp++;
      if (rdata1 !== exp_data(raddr1) || rbusy1 !== exp_busy(raddr1)) begin
        n_err++;
        $display("FAIL rand_port1 it%0d r%0d got %h/%b want %h/%b", it, raddr1, rdata1, rbusy1,
                 exp_data(raddr1), exp_busy(raddr1));
      end
      n_cmp++;
      if (rdata2 !== exp_data(raddr2) || rbusy2 !== exp_busy(raddr2)) begin
        n_err++;
        $display("FAIL rand_port2 it%0d r%0d got %h/%b want %h/%b", it, raddr2, rdata2, rbusy2,
                 exp_data(raddr2), exp_busy(raddr2));
      end
      tick();
      n_cmp++;
      if (busy_cnt !== 6'($countones(mdl_busy))) begin
        n_err++;
        $display("FAIL rand_cnt it%0d got %0d want %0d", it, busy_cnt, $countones(mdl_busy));
      end
    end
  endtask

  initial begin
    mdl_reset();
    #12;
    test_reset();
    test_zero_reg();
    test_alloc_writeback();
    test_same_cycle();
    test_flush();
    test_fill();
    test_bypass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
